// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for the 32x32 MIPS register file.
// Several writeback sources compete for the single write port. Each cycle one of
// them is granted through a valid/ready handshake. The winner is registered onto
// RegWrite/WriteRegister/WriteData, which feed the register file one cycle later.
// A write to $0 is accepted but never asserted to the file.
// Ports:
//   Clk, ResetN            clock; asynchronous active-low reset
//   Hold                   suppress all grants this cycle
//   ReqValid/Addr/Data     per-requester pending write (addr 5b, data 32b each)
//   ReqReady               one-hot combinational grant
//   RegWrite/WriteRegister/WriteData  registered write to the register file
//   FwdValid               in-flight write is valid (mirror of RegWrite)
//   WriteCount             saturating count of committed non-$0 writes
module regfile_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  Hold,
  input  logic [NUM_REQ-1:0]    ReqValid,
  input  logic [5*NUM_REQ-1:0]  ReqAddr,
  input  logic [32*NUM_REQ-1:0] ReqData,
  output logic [NUM_REQ-1:0]    ReqReady,
  output logic                  RegWrite,
  output logic [4:0]            WriteRegister,
  output logic [31:0]           WriteData,
  output logic                  FwdValid,
  output logic [CNT_W-1:0]      WriteCount
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {StIdle, StWrite} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [4:0]        addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              found;
  int unsigned       gnt_idx;
  logic [4:0]        sel_addr;
  logic [31:0]       sel_data;

  // Search from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    int unsigned idx;
    ReqReady = '0;
    found    = 1'b0;
    gnt_idx  = 0;
    idx      = 0;
    if (ResetN && !Hold) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && ReqValid[idx]) begin
          found         = 1'b1;
          gnt_idx       = idx;
          ReqReady[idx] = 1'b1;
        end
      end
    end
  end

  assign sel_addr = ReqAddr[5*gnt_idx +: 5];
  assign sel_data = ReqData[32*gnt_idx +: 32];

  always_comb begin
    int unsigned nxt;
    state_d = StIdle;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    nxt     = gnt_idx + 1;
    if (found) begin
      ptr_d  = (nxt >= NUM_REQ) ? '0 : PtrW'(nxt);
      addr_d = sel_addr;
      data_d = sel_data;
      // $0 transfers complete the handshake but never reach the file.
      if (sel_addr != 5'd0) state_d = StWrite;
    end
    cnt_d = cnt_q;
    if (state_q == StWrite && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign RegWrite      = (state_q == StWrite);
  assign FwdValid      = (state_q == StWrite);
  assign WriteRegister = addr_q;
  assign WriteData     = data_q;
  assign WriteCount    = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic         Clk = 1'b0;
  logic         ResetN = 1'b0;
  logic         Hold = 1'b0;
  logic [3:0]   ReqValid = 4'b0;
  logic [4:0]   a [4];
  logic [31:0]  d [4];
  logic [19:0]  ReqAddr;
  logic [127:0] ReqData;
  logic [3:0]   ReqReady, ReqReady2;
  logic         RegWrite, RegWrite2, FwdValid, FwdValid2;
  logic [4:0]   WriteRegister, WriteRegister2;
  logic [31:0]  WriteData, WriteData2;
  logic [15:0]  WriteCount;
  logic [1:0]   WriteCount2;

  logic [31:0]  rf [32];

  int total = 0;
  int bad = 0;

  // Reference model state
  int          m_ptr, m_cnt, m_cnt2, m_last_g;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  always #5 Clk = ~Clk;

  always_comb begin
    ReqAddr = '0;
    ReqData = '0;
    for (int i = 0; i < 4; i++) begin
      ReqAddr[5*i +: 5]   = a[i];
      ReqData[32*i +: 32] = d[i];
    end
  end

  regfile_write_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
    .Clk(Clk), .ResetN(ResetN), .Hold(Hold), .ReqValid(ReqValid), .ReqAddr(ReqAddr),
    .ReqData(ReqData), .ReqReady(ReqReady), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .FwdValid(FwdValid),
    .WriteCount(WriteCount)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  regfile_write_arbiter #(.NUM_REQ(4), .CNT_W(2)) dut_sat (
    .Clk(Clk), .ResetN(ResetN), .Hold(Hold), .ReqValid(ReqValid), .ReqAddr(ReqAddr),
    .ReqData(ReqData), .ReqReady(ReqReady2), .RegWrite(RegWrite2),
    .WriteRegister(WriteRegister2), .WriteData(WriteData2), .FwdValid(FwdValid2),
    .WriteCount(WriteCount2)
  );

  // Register file fed by the arbiter outputs.
  initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  always @(posedge Clk) if (RegWrite && WriteRegister != 5'd0) rf[WriteRegister] <= WriteData;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_grant(input int p, input logic h, input logic [3:0] v);
    if (h || v == 4'b0) return -1;
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_cnt = 0; m_cnt2 = 0;
    m_last_g = -1;
  endtask

  // One clock: compare against the model at negedge, advance the model at posedge.
  task automatic cycle();
    int g;
    logic [3:0] eg;
    @(negedge Clk);
    g  = model_grant(m_ptr, Hold, ReqValid);
    eg = (g < 0) ? 4'b0 : (4'b1 << g);
    chk("m_ready", ReqReady, eg);
    chk("m_regwrite", RegWrite, m_we);
    chk("m_fwd", FwdValid, m_we);
    chk("m_waddr", WriteRegister, m_addr);
    chk("m_wdata", WriteData, m_data);
    chk("m_count", WriteCount, m_cnt);
    chk("m_count_sat", WriteCount2, m_cnt2);
    @(posedge Clk);
    if (m_we) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (g >= 0) begin
      m_ptr = (g + 1) % 4; m_addr = a[g]; m_data = d[g]; m_we = (a[g] != 5'd0);
    end else begin
      m_we = 1'b0;
    end
    m_last_g = g;
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    ResetN = 1'b0;
    #1;
    chk("rst_ready", ReqReady, 4'b0);
    chk("rst_regwrite", RegWrite, 1'b0);
    chk("rst_count", WriteCount, 16'd0);
    model_reset();
    @(posedge Clk);
    #2 ResetN = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    bit         hold;
    logic [3:0] valid;
    logic [3:0] ready;
    bit         we;
    int         cnt;
  } vec_t;

  vec_t tbl [15];

  initial begin
    for (int i = 0; i < 4; i++) begin a[i] = 5'd0; d[i] = 32'd0; end
    model_reset();

    // Reset state; grants are gated while ResetN is low.
    ReqValid = 4'b1111;
    #3;
    chk("reset_ready", ReqReady, 4'b0);
    chk("reset_regwrite", RegWrite, 1'b0);
    chk("reset_waddr", WriteRegister, 5'd0);
    chk("reset_wdata", WriteData, 32'd0);
    chk("reset_count", WriteCount, 16'd0);
    ReqValid = 4'b0;
    @(posedge Clk);
    #2 ResetN = 1'b1;

    // Single write to $5.
    a[0] = 5'd5; d[0] = 32'hDEADBEEF; ReqValid = 4'b0001;
    #1 chk("t1_ready", ReqReady, 4'b0001);
    cycle();
    ReqValid = 4'b0;
    chk("t1_regwrite", RegWrite, 1'b1);
    chk("t1_waddr", WriteRegister, 5'd5);
    chk("t1_wdata", WriteData, 32'hDEADBEEF);
    cycle();
    chk("t1_rf5", rf[5], 32'hDEADBEEF);
    chk("t1_count", WriteCount, 16'd1);

    // $0 write is acknowledged but dropped.
    a[2] = 5'd0; d[2] = 32'hFFFFFFFF; ReqValid = 4'b0100;
    #1 chk("t3_ready", ReqReady, 4'b0100);
    cycle();
    ReqValid = 4'b0;
    chk("t3_regwrite", RegWrite, 1'b0);
    cycle();
    chk("t3_rf0", rf[0], 32'd0);
    chk("t3_count", WriteCount, 16'd1);

    // Rotation with all valid, then hold behaviour.
    tbl = '{
      '{1, 0, 4'b1111, 4'b0001, 0, 0}, '{0, 0, 4'b1111, 4'b0010, 1, 0},
      '{0, 0, 4'b1111, 4'b0100, 1, 1}, '{0, 0, 4'b1111, 4'b1000, 1, 2},
      '{0, 0, 4'b1111, 4'b0001, 1, 3}, '{0, 0, 4'b1111, 4'b0010, 1, 4},
      '{0, 0, 4'b0000, 4'b0000, 1, 5}, '{0, 0, 4'b0000, 4'b0000, 0, 6},
      '{1, 1, 4'b1010, 4'b0000, 0, 0}, '{0, 1, 4'b1010, 4'b0000, 0, 0},
      '{0, 1, 4'b1010, 4'b0000, 0, 0}, '{0, 0, 4'b1010, 4'b0010, 0, 0},
      '{0, 0, 4'b1000, 4'b1000, 1, 0}, '{0, 0, 4'b0000, 4'b0000, 1, 1},
      '{0, 0, 4'b0000, 4'b0000, 0, 2}
    };
    for (int i = 0; i < 4; i++) begin a[i] = 5'(i + 1); d[i] = 32'h11 * (i + 1); end
    for (int r = 0; r < 15; r++) begin
      if (tbl[r].rst) begin ReqValid = 4'b0; Hold = 1'b0; do_reset(); end
      Hold = tbl[r].hold; ReqValid = tbl[r].valid;
      #1;
      chk($sformatf("tbl%0d_ready", r), ReqReady, tbl[r].ready);
      chk($sformatf("tbl%0d_regwrite", r), RegWrite, tbl[r].we);
      chk($sformatf("tbl%0d_count", r), WriteCount, tbl[r].cnt);
      cycle();
    end
    Hold = 1'b0;

    // Reset between acceptance and commit loses the write.
    a[1] = 5'd7; d[1] = 32'h1234; ReqValid = 4'b0010;
    cycle();
    chk("t5_pending", RegWrite, 1'b1);
    ReqValid = 4'b1111;
    #1 ResetN = 1'b0;
    #1;
    chk("t5_regwrite", RegWrite, 1'b0);
    chk("t5_count", WriteCount, 16'd0);
    chk("t5_ready_gated", ReqReady, 4'b0);
    model_reset();
    @(posedge Clk);
    #2 ResetN = 1'b1;
    #1 chk("t5_ptr0", ReqReady, 4'b0001);
    chk("t5_rf7", rf[7], 32'd0);
    ReqValid = 4'b0;
    cycle();

    // Randomised traffic against the model, honouring the handshake rules.
    for (int n = 0; n < 400; n++) begin
      Hold = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!ReqValid[i] && $urandom_range(0, 1) == 1) begin
          ReqValid[i] = 1'b1; a[i] = 5'($urandom_range(0, 31)); d[i] = $urandom;
        end
      end
      cycle();
      if (m_last_g >= 0) begin
        if ($urandom_range(0, 1) == 1) ReqValid[m_last_g] = 1'b0;
        else begin a[m_last_g] = 5'($urandom_range(0, 31)); d[m_last_g] = $urandom; end
      end
    end
    Hold = 1'b0; ReqValid = 4'b0;
    cycle();
    cycle();
    chk("sat_count", WriteCount2, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
